// File: rtl/timer_pkg.sv
// Shared definitions for the timer block: widths, prescaler limits,
// register map offsets and the counter write-select encoding.
package timer_pkg;

  localparam int CNT_W       = 64;
  localparam int DIV_W       = 4;
  localparam int DIV_VAL_MAX = 8;

  // Register map offsets used by the bus-facing wrapper of the timer.
  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_DIV    = 8'h04;
  localparam logic [7:0] ADDR_CNT_LO = 8'h08;
  localparam logic [7:0] ADDR_CNT_HI = 8'h0C;
  localparam logic [7:0] ADDR_STATUS = 8'h10;

  typedef enum logic [1:0] {
    WR_NONE = 2'b00,
    WR_LO   = 2'b01,
    WR_HI   = 2'b10,
    WR_BOTH = 2'b11
  } wr_sel_e;

  // Terminal prescaler count for exponent e: 2^e - 1 (e <= DIV_VAL_MAX fits 9 bits).
  function automatic logic [8:0] div_limit(input logic [DIV_W-1:0] exp_val);
    return 9'((9'd1 << exp_val) - 9'd1);
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the timer: divides the count rate by 2^div_val when div_en is
// set, and restarts whenever the divisor settings change.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             run,
  input  logic             clear,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  output logic             tick
);

  logic [7:0]       div_cnt;
  logic             div_en_q;
  logic [DIV_W-1:0] div_val_q;
  logic             changed;

  assign changed = (div_en != div_en_q) || (div_val != div_val_q);

  // A settings change restarts the period, so no divided tick is issued in
  // that cycle; with the prescaler bypassed every cycle ticks.
  assign tick = !div_en || (!changed && ({1'b0, div_cnt} == div_limit(div_val)));

  // Prescale counter and registered copies of the divisor settings.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      div_cnt   <= '0;
      div_en_q  <= 1'b0;
      div_val_q <= DIV_W'(1);
    end else begin
      div_en_q  <= div_en;
      div_val_q <= div_val;
      if (clear || changed) begin
        div_cnt <= '0;
      end else if (run) begin
        div_cnt <= tick ? '0 : div_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/timer_counter.sv
// 64-bit free-running timer with prescaler, software clear/write and an
// optional debug halt (enabled by defining TIMER_HALT_EN).
module timer_counter #(
  parameter int CNT_W = timer_pkg::CNT_W,
  parameter int DIV_W = timer_pkg::DIV_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             timer_en,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             halt_req,
  input  logic             debug_mode,
  input  logic             counter_clear,
  input  logic [1:0]       counter_write_sel,
  input  logic [31:0]      counter_write_data,
  output logic [CNT_W-1:0] cnt_val,
  output logic             halt_ack_status
);

  logic              tick;
  logic              run;
  timer_pkg::wr_sel_e wr_sel;

  assign run    = timer_en && !halt_ack_status;
  assign wr_sel = timer_pkg::wr_sel_e'(counter_write_sel);

  timer_prescaler u_prescaler (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .run     (run),
    .clear   (counter_clear || !timer_en),
    .div_en  (div_en),
    .div_val (div_val),
    .tick    (tick)
  );

`ifdef TIMER_HALT_EN
  // Halt acknowledge follows the qualified request with one cycle of latency.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      halt_ack_status <= 1'b0;
    end else begin
      halt_ack_status <= halt_req && debug_mode;
    end
  end
`else
  logic unused_halt;
  assign unused_halt     = halt_req ^ debug_mode;
  assign halt_ack_status = 1'b0;
`endif

  // Counter update: clear beats write, write beats (and swallows) increment.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_val <= '0;
    end else if (counter_clear) begin
      cnt_val <= '0;
    end else if (wr_sel != timer_pkg::WR_NONE) begin
      case (wr_sel)
        timer_pkg::WR_LO:   cnt_val[31:0]  <= counter_write_data;
        timer_pkg::WR_HI:   cnt_val[63:32] <= counter_write_data;
        timer_pkg::WR_BOTH: cnt_val        <= {counter_write_data, counter_write_data};
        default:            cnt_val        <= cnt_val;
      endcase
    end else if (run && tick) begin
      cnt_val <= cnt_val + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: stimulus pushes expected state, a
// monitor process pops and compares against the DUT outputs.
module tb_timer_counter;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        timer_en;
  logic        div_en;
  logic [3:0]  div_val;
  logic        halt_req;
  logic        debug_mode;
  logic        counter_clear;
  logic [1:0]  counter_write_sel;
  logic [31:0] counter_write_data;
  logic [63:0] cnt_val;
  logic        halt_ack_status;

  typedef struct {
    string       name;
    logic [63:0] cnt;
    logic        halt;
  } exp_t;

  exp_t sb[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;

  timer_counter #(.CNT_W(64), .DIV_W(4)) dut (
    .sys_clk            (sys_clk),
    .sys_rst            (sys_rst),
    .timer_en           (timer_en),
    .div_en             (div_en),
    .div_val            (div_val),
    .halt_req           (halt_req),
    .debug_mode         (debug_mode),
    .counter_clear      (counter_clear),
    .counter_write_sel  (counter_write_sel),
    .counter_write_data (counter_write_data),
    .cnt_val            (cnt_val),
    .halt_ack_status    (halt_ack_status)
  );

  always #5 sys_clk = ~sys_clk;

  // Monitor: compares DUT outputs against every queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (cnt_val !== e.cnt || halt_ack_status !== e.halt) begin
          errors++;
          $display("FAIL %s: cnt_val=%h expected %h, halt_ack=%b expected %b",
                   e.name, cnt_val, e.cnt, halt_ack_status, e.halt);
        end
      end
    end
  end

  task automatic expect_state(input string nm, input logic [63:0] c, input logic h);
    exp_t e;
    e.name = nm;
    e.cnt  = c;
    e.halt = h;
    sb.push_back(e);
    ->chk_ev;
    #1;
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge sys_clk);
  endtask

  initial begin
    sys_rst            = 1'b1;
    timer_en           = 1'b0;
    div_en             = 1'b0;
    div_val            = 4'd0;
    halt_req           = 1'b0;
    debug_mode         = 1'b0;
    counter_clear      = 1'b0;
    counter_write_sel  = 2'b00;
    counter_write_data = '0;
    #2;
    expect_state("reset_state", 64'd0, 1'b0);
    step(2);
    sys_rst = 1'b0;

    // Free-running count with prescaler bypassed.
    timer_en = 1'b1;
    step(10);
    expect_state("count_10", 64'd10, 1'b0);

    // Prescaler /4: settings staged while stopped so the period starts clean.
    timer_en = 1'b0; counter_clear = 1'b1; div_en = 1'b1; div_val = 4'd2;
    step(1);
    expect_state("clear_pulse", 64'd0, 1'b0);
    counter_clear = 1'b0; timer_en = 1'b1;
    step(3);
    expect_state("div4_before_tick", 64'd0, 1'b0);
    step(1);
    expect_state("div4_first_tick", 64'd1, 1'b0);
    step(8);
    expect_state("div4_12_cycles", 64'd3, 1'b0);
    step(1);
    div_val = 4'd0;
    step(1);
    expect_state("divval_change_restart", 64'd3, 1'b0);
    step(1);
    expect_state("divval_change_next", 64'd4, 1'b0);
    step(1);
    expect_state("div1_every_cycle", 64'd5, 1'b0);

    // Write both halves then wrap through zero.
    timer_en = 1'b0; div_en = 1'b0;
    counter_write_sel = 2'b11; counter_write_data = 32'hFFFF_FFFF;
    step(1);
    expect_state("write_both", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    counter_write_sel = 2'b00; timer_en = 1'b1;
    step(1);
    expect_state("wrap_to_zero", 64'd0, 1'b0);

    // Half writes while counting: increment is swallowed in the write cycle.
    counter_write_sel = 2'b01; counter_write_data = 32'h0000_0010;
    step(1);
    expect_state("write_lo_no_inc", 64'h0000_0000_0000_0011 - 64'd1, 1'b0);
    counter_write_sel = 2'b10; counter_write_data = 32'h0000_ABCD;
    step(1);
    expect_state("write_hi_keeps_lo", 64'h0000_ABCD_0000_0010, 1'b0);
    counter_write_sel = 2'b00;
    step(1);
    expect_state("inc_after_write", 64'h0000_ABCD_0000_0011, 1'b0);

    // Clear wins over a same-cycle write.
    timer_en = 1'b0;
    counter_clear = 1'b1; counter_write_sel = 2'b01; counter_write_data = 32'h0000_1234;
    step(1);
    expect_state("clear_beats_write", 64'd0, 1'b0);
    counter_clear = 1'b0; counter_write_sel = 2'b00;

    // Halt behaviour.
    timer_en = 1'b1;
    step(5);
    expect_state("pre_halt_count", 64'd5, 1'b0);
    halt_req = 1'b1; debug_mode = 1'b1;
    step(1);
`ifdef TIMER_HALT_EN
    expect_state("halt_ack_set", 64'd6, 1'b1);
    step(3);
    expect_state("halt_holds", 64'd6, 1'b1);
    counter_write_sel = 2'b01; counter_write_data = 32'h0000_0020;
    step(1);
    expect_state("write_while_halted", 64'h20, 1'b1);
    counter_write_sel = 2'b00; debug_mode = 1'b0;
    step(1);
    expect_state("halt_ack_clear", 64'h20, 1'b0);
    step(1);
    expect_state("resume_after_halt", 64'h21, 1'b0);
    halt_req = 1'b0;
`else
    expect_state("halt_ignored_1", 64'd6, 1'b0);
    step(3);
    expect_state("halt_ignored_2", 64'd9, 1'b0);
    halt_req = 1'b0; debug_mode = 1'b0;
`endif

    // Asynchronous reset mid-count.
    timer_en = 1'b1; counter_clear = 1'b1;
    step(1);
    counter_clear = 1'b0;
    step(100);
    expect_state("count_100", 64'd100, 1'b0);
    #1;
    sys_rst = 1'b1;
    #1;
    expect_state("async_reset_immediate", 64'd0, 1'b0);
    step(2);
    sys_rst = 1'b0;
    step(1);
    expect_state("resume_after_reset", 64'd1, 1'b0);

    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
